// File: rtl/sisc_exec_core_if.sv
// sisc_exec_core_if: bundles the instruction, register-file operands and
// all execution-core results into one connection.
//   master : environment side. Drives ir, rsa, rsb and mem_data, and observes the results.
//   slave  : core side. Observes the inputs and drives alu_result, stat,
//            stat_en, alu_op, wb_sel, write_data, rf_we and state.
interface sisc_exec_core_if;
  logic [31:0] ir;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [31:0] mem_data;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic [31:0] write_data;
  logic        rf_we;
  logic [2:0]  state;

  modport master (
    output ir, rsa, rsb, mem_data,
    input  alu_result, stat, stat_en, alu_op, wb_sel, write_data, rf_we, state
  );

  modport slave (
    input  ir, rsa, rsb, mem_data,
    output alu_result, stat, stat_en, alu_op, wb_sel, write_data, rf_we, state
  );
endinterface

// File: rtl/sisc_exec_core.sv
// sisc_exec_core: multi-cycle control FSM plus combinational ALU for the SISC
// execution core. Each instruction walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Opcode 1111 parks the FSM in HALT until reset.
//   clk   : rising-edge clock
//   rst_f : asynchronous active-low reset. While it is low, every output
//           is forced to its idle value.
//   bus   : slave side of sisc_exec_core_if
//     in  : ir (opcode [31:28], mm [27:24], imm [15:0]), rsa, rsb, mem_data
//     out : alu_result, stat {C,N,V,Z}, stat_en, alu_op, wb_sel,
//           write_data, rf_we, state
module sisc_exec_core (
  input  logic            clk,
  input  logic            rst_f,
  sisc_exec_core_if.slave bus
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    START0    = 3'd0,
    START1    = 3'd1,
    FETCH     = 3'd2,
    DECODE    = 3'd3,
    EXECUTE   = 3'd4,
    MEM       = 3'd5,
    WRITEBACK = 3'd6,
    HALT      = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        opcode;
  logic [3:0]        mm;
  logic [15:0]       imm;
  logic              is_alu;
  logic              is_real_fn;
  logic              in_alu_phase;
  logic [1:0]        alu_op;
  logic              stat_en;
  logic              rf_we;
  logic              wb_sel;
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W-1:0] result;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              carry;
  logic              ovf;
  logic [3:0]        flags;

  assign opcode = bus.ir[31:28];
  assign mm     = bus.ir[27:24];
  assign imm    = bus.ir[15:0];

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Signed overflow on A-B: operand signs differ and the result sign differs from A.
  function automatic logic sub_ovf(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= START0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START0:    state_d = START1;
      START1:    state_d = FETCH;
      FETCH:     state_d = DECODE;
      DECODE:    state_d = (opcode == 4'b1111) ? HALT : EXECUTE;
      EXECUTE:   state_d = MEM;
      MEM:       state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = START0;
    endcase
  end

  // Every control output is gated by rst_f, so reset takes effect
  // immediately, without waiting for the state register.
  always_comb begin
    is_alu       = (opcode == 4'b0001) || (opcode == 4'b0010);
    is_real_fn   = (mm >= 4'd1) && (mm <= 4'd8);
    in_alu_phase = (state_q == EXECUTE) || (state_q == MEM) || (state_q == WRITEBACK);
    alu_op       = 2'b00;
    stat_en      = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    if (rst_f && is_alu) begin
      if (in_alu_phase)
        alu_op = (opcode == 4'b0001) ? 2'b01 : 2'b10;
      stat_en = is_real_fn && (state_q == EXECUTE);
      rf_we   = is_real_fn && (state_q == WRITEBACK);
    end
  end

  // alu_op 00 and the reserved code 11 both leave the ALU idle, with a
  // zero result and zero flags.
  always_comb begin
    b_opnd = '0;
    result = '0;
    sum    = '0;
    diff   = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    flags  = 4'b0000;
    if ((alu_op == 2'b01) || (alu_op == 2'b10)) begin
      b_opnd = (alu_op == 2'b01) ? bus.rsb : {16'h0000, imm};
      sum    = {1'b0, bus.rsa} + {1'b0, b_opnd};
      diff   = bus.rsa - b_opnd;
      unique case (mm)
        4'b0001: begin
          result = sum[DATA_W-1:0];
          carry  = sum[DATA_W];
          ovf    = add_ovf(bus.rsa, b_opnd, sum[DATA_W-1:0]);
        end
        4'b0010: begin
          result = diff;
          carry  = (bus.rsa < b_opnd);
          ovf    = sub_ovf(bus.rsa, b_opnd, diff);
        end
        4'b0011: result = ~bus.rsa;
        4'b0100: result = bus.rsa | b_opnd;
        4'b0101: result = bus.rsa & b_opnd;
        4'b0110: result = bus.rsa ^ b_opnd;
        4'b0111: result = bus.rsa << b_opnd[4:0];
        4'b1000: result = bus.rsa >> b_opnd[4:0];
        default: result = bus.rsa;
      endcase
      flags = {carry, result[DATA_W-1], ovf, (result == '0)};
    end
  end

  assign bus.alu_result = result;
  assign bus.stat       = flags;
  assign bus.stat_en    = stat_en;
  assign bus.alu_op     = alu_op;
  assign bus.wb_sel     = wb_sel;
  assign bus.write_data = wb_sel ? bus.mem_data : result;
  assign bus.rf_we      = rf_we;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_sisc_exec_core.sv
// tb_sisc_exec_core: directed and randomized stimulus for sisc_exec_core.
// A behavioural reference model is checked on every falling clock edge.
// Fixed-value checks at key points pin both the model and the DUT.
module tb_sisc_exec_core;

  logic clk = 1'b0;
  logic rst_f;
  sisc_exec_core_if bus ();

  sisc_exec_core dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  st;
    logic        se;
    logic [1:0]  op;
    logic        wb;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  s;
  } exp_t;

  exp_t ce;
  logic [2:0] m_state = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the instruction walk: linear through the start-up and execute
  // phases, with WRITEBACK looping back to FETCH and HALT absorbing.
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f)                m_state <= 3'd0;
    else if (m_state == 3'd3)  m_state <= (bus.ir[31:28] == 4'hF) ? 3'd7 : 3'd4;
    else if (m_state == 3'd6)  m_state <= 3'd2;
    else if (m_state != 3'd7)  m_state <= m_state + 3'd1;
  end

  function automatic exp_t model(input logic [2:0] st, input logic rst,
                                 input logic [31:0] ir, input logic [31:0] a,
                                 input logic [31:0] rb, input logic [31:0] md);
    exp_t e;
    logic [3:0] opc, fn;
    logic [31:0] b, r;
    longint unsigned ua, ub, full;
    longint sa, sb, ss;
    logic c, v, alu_ins, real_fn;
    e = '0;
    if (!rst) return e;
    e.s = st;
    opc = ir[31:28];
    fn  = ir[27:24];
    alu_ins = (opc == 4'd1) || (opc == 4'd2);
    real_fn = (fn >= 4'd1) && (fn <= 4'd8);
    if (alu_ins && (st >= 3'd4) && (st <= 3'd6)) e.op = (opc == 4'd1) ? 2'd1 : 2'd2;
    if (e.op != 2'd0) begin
      b  = (opc == 4'd1) ? rb : {16'h0, ir[15:0]};
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      c = 1'b0; v = 1'b0;
      case (fn)
        4'd1: begin
          full = ua + ub; r = full[31:0]; c = (full >> 32) != 0;
          ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        4'd2: begin
          full = ua - ub; r = full[31:0]; c = ua < ub;
          ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        4'd3: r = ~a;
        4'd4: r = a | b;
        4'd5: r = a & b;
        4'd6: r = a ^ b;
        4'd7: begin full = (ua << ub[4:0]); r = full[31:0]; end
        4'd8: begin full = (ua >> ub[4:0]); r = full[31:0]; end
        default: r = a;
      endcase
      e.res = r;
      e.st  = {c, r[31], v, (r == 32'd0)};
    end
    e.se = alu_ins && real_fn && (st == 3'd4);
    e.we = alu_ins && real_fn && (st == 3'd6);
    e.wb = 1'b0;
    e.wd = e.res;
    return e;
  endfunction

  always @(negedge clk) begin
    ce = model(m_state, rst_f, bus.ir, bus.rsa, bus.rsb, bus.mem_data);
    chk("cyc_state",      32'(bus.state),   32'(ce.s));
    chk("cyc_alu_result", bus.alu_result,   ce.res);
    chk("cyc_stat",       32'(bus.stat),    32'(ce.st));
    chk("cyc_stat_en",    32'(bus.stat_en), 32'(ce.se));
    chk("cyc_alu_op",     32'(bus.alu_op),  32'(ce.op));
    chk("cyc_wb_sel",     32'(bus.wb_sel),  32'(ce.wb));
    chk("cyc_write_data", bus.write_data,   ce.wd);
    chk("cyc_rf_we",      32'(bus.rf_we),   32'(ce.we));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [2:0] target);
    int n = 0;
    while (m_state != target && n < 16) begin
      step();
      n++;
    end
    chk("run_to_state", 32'(m_state), 32'(target));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [3:0] op;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 2)      op = 4'h0;
    else if (sel < 5) op = 4'h1;
    else if (sel < 8) op = 4'h2;
    else              op = 4'($urandom_range(3, 14));
    return {op, 4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom)};
  endfunction

  initial begin
    rst_f        = 1'b1;
    bus.ir       = 32'h1100_0000;
    bus.rsa      = 32'd5;
    bus.rsb      = 32'd7;
    bus.mem_data = 32'hDEAD_BEEF;
    #1 rst_f = 1'b0;
    #2;
    // Reset forces idle outputs even with a live ADD on the inputs.
    chk("rst_state",      32'(bus.state),   32'd0);
    chk("rst_alu_op",     32'(bus.alu_op),  32'd0);
    chk("rst_alu_result", bus.alu_result,   32'd0);
    chk("rst_stat",       32'(bus.stat),    32'd0);
    chk("rst_write_data", bus.write_data,   32'd0);
    chk("rst_rf_we",      32'(bus.rf_we),   32'd0);
    chk("rst_stat_en",    32'(bus.stat_en), 32'd0);
    chk("rst_wb_sel",     32'(bus.wb_sel),  32'd0);

    // NOP walk through the full state sequence.
    bus.ir = 32'h0000_0000;
    @(posedge clk); #1;
    rst_f = 1'b1;
    chk("nop_seq_0", 32'(bus.state), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("nop_seq", 32'(bus.state), (i == 7) ? 32'd2 : 32'(i));
      chk("nop_rf_we", 32'(bus.rf_we), 32'd0);
      chk("nop_stat_en", 32'(bus.stat_en), 32'd0);
    end

    // Register ADD: 5 + 7.
    bus.ir = 32'h1100_0000; bus.rsa = 32'd5; bus.rsb = 32'd7;
    step(); step();
    chk("add_state",   32'(bus.state),   32'd4);
    chk("add_alu_op",  32'(bus.alu_op),  32'd1);
    chk("add_result",  bus.alu_result,   32'd12);
    chk("add_stat",    32'(bus.stat),    32'h0);
    chk("add_stat_en", 32'(bus.stat_en), 32'd1);
    step(); step();
    chk("add_wb_rf_we", 32'(bus.rf_we),  32'd1);
    chk("add_wb_data",  bus.write_data,  32'd12);
    run_to(3'd2);

    // SUB: equal operands, then borrow.
    bus.ir = 32'h1200_0000; bus.rsa = 32'd3; bus.rsb = 32'd3;
    step(); step();
    chk("sub_zero_result", bus.alu_result, 32'd0);
    chk("sub_zero_stat",   32'(bus.stat),  32'b0001);
    bus.rsa = 32'd0; bus.rsb = 32'd1;
    #1;
    chk("sub_borrow_result", bus.alu_result, 32'hFFFF_FFFF);
    chk("sub_borrow_stat",   32'(bus.stat),  32'b1100);
    run_to(3'd2);

    // Immediate ADD with a zero-extended 0x8000, then register overflow.
    bus.ir = 32'h2100_8000; bus.rsa = 32'h7FFF_FFFF; bus.rsb = 32'hFFFF_FFFF;
    step(); step();
    chk("addi_alu_op", 32'(bus.alu_op), 32'd2);
    chk("addi_result", bus.alu_result,  32'h8000_7FFF);
    chk("addi_stat",   32'(bus.stat),   32'b0110);
    run_to(3'd2);
    bus.ir = 32'h1100_0000; bus.rsa = 32'h7FFF_FFFF; bus.rsb = 32'd1;
    step(); step();
    chk("ovf_result", bus.alu_result, 32'h8000_0000);
    chk("ovf_stat",   32'(bus.stat),  32'b0110);
    run_to(3'd2);

    // Randomized instruction stream.
    for (int k = 0; k < 1500; k++) begin
      step();
      bus.rsa      = pick();
      bus.rsb      = pick();
      bus.mem_data = $urandom;
      if (m_state == 3'd2) bus.ir = rand_ir();
    end
    run_to(3'd2);

    // Reset pulsed during EXECUTE of an ADD aborts the instruction.
    bus.ir = 32'h1100_0000; bus.rsa = 32'd9; bus.rsb = 32'd1;
    step(); step();
    chk("abort_pre_stat_en", 32'(bus.stat_en), 32'd1);
    #1 rst_f = 1'b0;
    #1;
    chk("abort_stat_en", 32'(bus.stat_en), 32'd0);
    chk("abort_alu_op",  32'(bus.alu_op),  32'd0);
    chk("abort_rf_we",   32'(bus.rf_we),   32'd0);
    chk("abort_state",   32'(bus.state),   32'd0);
    @(posedge clk); #1;
    rst_f = 1'b1;
    chk("abort_restart_0", 32'(bus.state), 32'd0);
    step();
    chk("abort_restart_1", 32'(bus.state), 32'd1);
    run_to(3'd2);

    // HALT holds until reset, which clears it asynchronously.
    bus.ir = 32'hF000_0000;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 32'(bus.state), 32'd7);
      chk("halt_rf_we", 32'(bus.rf_we), 32'd0);
      step();
    end
    #1 rst_f = 1'b0;
    #1;
    chk("halt_async_reset", 32'(bus.state), 32'd0);
    step();
    rst_f = 1'b1;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
